// File: rtl/vector_checker.sv
// Exhaustive stimulus/response checker for a small combinational unit.
// Optional first-failing-vector capture: define VECTOR_CHECKER_FIRST_FAIL_EN.
module vector_checker #(
   parameter int unsigned           N_IN     = 3,
   parameter int unsigned           HOLD     = 2,
   parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'h31
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] vec,
   input  logic            y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail
);

   localparam int unsigned DEPTH = 2**N_IN;
   localparam int unsigned HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q;
   logic [N_IN-1:0] vec_q;
   logic [HW-1:0]   hold_q;
   logic [N_IN:0]   err_q;
   logic [N_IN:0]   err_d;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            mismatch;

`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
   logic [N_IN-1:0] ff_q;
`endif

   // Only meaningful on compare cycles; the FSM ignores it elsewhere.
   always_comb begin
      mismatch = (y != EXPECTED[vec_q]);
      err_d    = err_q + (N_IN+1)'(mismatch);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         hold_q  <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
         ff_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= RUN;
                  vec_q   <= '0;
                  hold_q  <= '0;
                  err_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
                  ff_q    <= '0;
`endif
               end
            end
            RUN: begin
               if (hold_q == HOLD_LAST) begin
                  err_q  <= err_d;
                  hold_q <= '0;
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
                  if (mismatch && (err_q == '0))
                     ff_q <= vec_q;
`endif
                  // Last vector: pass reflects the count including this compare.
                  if (vec_q == VEC_LAST) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end else begin
                     vec_q <= vec_q + 1'b1;
                  end
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign vec       = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
   assign first_fail = ff_q;
`else
   assign first_fail = '0;
`endif

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: default HOLD=2 instance plus a HOLD=1 instance.
module tb_vector_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, start1;
   logic [2:0] vec, vec1;
   logic       y, y1;
   logic       busy, done, pass, busy1, done1, pass1;
   logic [3:0] err_count, err_count1;
   logic [2:0] first_fail, first_fail1;
   int         mode;   // 0 = correct unit, 1 = stuck at 0, 2 = stuck at 1
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   // Correct unit: y = 1 for vectors 0, 4, 5
   assign y  = (mode == 0) ? (~vec[1] & (vec[2] | ~vec[0])) : (mode == 2);
   assign y1 = ~vec1[1] & (vec1[2] | ~vec1[0]);

   vector_checker #(.N_IN(3), .HOLD(2), .EXPECTED(8'h31)) dut (
      .clk(clk), .reset(reset), .start(start), .vec(vec), .y(y),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail(first_fail)
   );

   vector_checker #(.N_IN(3), .HOLD(1), .EXPECTED(8'h31)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .vec(vec1), .y(y1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
      .first_fail(first_fail1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start sampled at the posedge between the two negedges; returns after edge k.
   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
      #12;
      check("rst_vec", 32'(vec), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_err", 32'(err_count), 0);
      check("rst_ff", 32'(first_fail), 0);
      @(negedge clk) reset = 1'b0;

      // Correct unit: vec steps 0..7, two cycles each, done after 16 edges
      pulse_start();
      check("run_busy", 32'(busy), 1);
      check("run_vec0", 32'(vec), 0);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         check("run_vec", 32'(vec), 32'(i / 2));
      end
      check("run_done_early", 32'(done), 0);
      @(negedge clk);
      check("run_done", 32'(done), 1);
      check("run_busy_end", 32'(busy), 0);
      check("run_err", 32'(err_count), 0);
      check("run_pass", 32'(pass), 1);
      check("run_vec_hold", 32'(vec), 7);

      // Stuck at 0: vectors 0,4,5 mismatch
      mode = 1;
      pulse_start();
      repeat (16) @(negedge clk);
      check("s0_done", 32'(done), 1);
      check("s0_err", 32'(err_count), 3);
      check("s0_pass", 32'(pass), 0);
      check("s0_ff", 32'(first_fail), 0);

      // Stuck at 1: vectors 1,2,3,6,7 mismatch
      mode = 2;
      pulse_start();
      check("s1_clear_err", 32'(err_count), 0);
      check("s1_clear_done", 32'(done), 0);
      repeat (16) @(negedge clk);
      check("s1_err", 32'(err_count), 5);
      check("s1_pass", 32'(pass), 0);
`ifdef VECTOR_CHECKER_FIRST_FAIL_EN
      check("s1_ff", 32'(first_fail), 1);
`else
      check("s1_ff", 32'(first_fail), 0);
`endif

      // Async reset mid-run at vec=3, err_count=1 (stuck at 0)
      mode = 1;
      pulse_start();
      repeat (6) @(negedge clk);
      check("mid_vec", 32'(vec), 3);
      check("mid_err", 32'(err_count), 1);
      #2 reset = 1'b1;
      #1;
      check("ar_vec", 32'(vec), 0);
      check("ar_err", 32'(err_count), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_done", 32'(done), 0);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      check("ar_idle_busy", 32'(busy), 0);
      mode = 0;
      pulse_start();
      repeat (15) @(negedge clk);
      check("ar_run_done15", 32'(done), 0);
      @(negedge clk);
      check("ar_run_done16", 32'(done), 1);
      check("ar_run_pass", 32'(pass), 1);

      // Start re-pulsed at cycle 5 is ignored
      pulse_start();
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("rp_vec", 32'(vec), 2);
      repeat (10) @(negedge clk);
      check("rp_done15", 32'(done), 0);
      @(negedge clk);
      check("rp_done16", 32'(done), 1);
      check("rp_err", 32'(err_count), 0);
      pulse_start();
      check("rp_restart_done", 32'(done), 0);
      check("rp_restart_vec", 32'(vec), 0);
      check("rp_restart_busy", 32'(busy), 1);

      // HOLD = 1 instance: vec changes every cycle, done after 8 edges
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      check("h1_vec0", 32'(vec1), 0);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         check("h1_vec", 32'(vec1), 32'(i));
      end
      check("h1_done7", 32'(done1), 0);
      @(negedge clk);
      check("h1_done", 32'(done1), 1);
      check("h1_err", 32'(err_count1), 0);
      check("h1_pass", 32'(pass1), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
